pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl.sv | 156 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Match-level pong controller: match FSM, BCD countdown, scores and winner.
// Optional build macro PONG_SUDDEN_DEATH_EN: a timeout tie continues play until one side scores.
module pong_game_ctrl #(
   parameter int SEC_CYCLES = 25_000_000,
   parameter int GAME_SEC   = 99,
   parameter int WIN_SCORE  = 7,
   parameter int SERVE_SEC  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       miss1,
   input  logic       miss2,
   output logic       stop,
   output logic [3:0] sec1,
   output logic [3:0] sec0,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] winner,
   output logic       game_over
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SERVE = 2'd1, ST_PLAY = 2'd2, ST_OVER = 2'd3} state_t;

   localparam int         PW       = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
   localparam int         SW       = $clog2(SERVE_SEC + 1);
   localparam logic [3:0] TENS     = 4'(GAME_SEC / 10);
   localparam logic [3:0] UNITS    = 4'(GAME_SEC % 10);
   localparam logic [3:0] WIN_PTS  = 4'(WIN_SCORE);

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic [SW-1:0]   r_serve;
   logic            r_start_d;

   logic            w_start_edge;
   logic            w_tick;
   logic            w_miss;
   logic [3:0]      w_s1_nxt;
   logic [3:0]      w_s2_nxt;
   logic            w_win;
   logic            w_at_zero;
   logic            w_to;
   logic            w_sd_hold;
   logic            w_over;
   logic [7:0]      w_sec_dec;

   function automatic logic [1:0] win_code(input logic [3:0] a, input logic [3:0] b);
      if (a > b)      return 2'b01;
      else if (b > a) return 2'b10;
      else            return 2'b11;
   endfunction

   assign w_start_edge = start & ~r_start_d;
   assign w_tick       = (r_presc == PW'(SEC_CYCLES - 1));
   assign w_miss       = miss1 | miss2;
   // A double miss is a wash: only a single-sided miss awards the point.
   assign w_s1_nxt     = score1 + {3'd0, miss2 & ~miss1};
   assign w_s2_nxt     = score2 + {3'd0, miss1 & ~miss2};
   assign w_win        = w_miss & ((w_s1_nxt == WIN_PTS) | (w_s2_nxt == WIN_PTS));
   assign w_at_zero    = (sec1 == 4'd0) & (sec0 == 4'd0);
   assign w_to         = w_tick & (sec1 == 4'd0) & (sec0 == 4'd1);
   assign w_sec_dec    = (sec0 == 4'd0) ? {sec1 - 4'd1, 4'd9} : {sec1, sec0 - 4'd1};
`ifdef PONG_SUDDEN_DEATH_EN
   assign w_sd_hold    = (w_s1_nxt == w_s2_nxt);
`else
   assign w_sd_hold    = 1'b0;
`endif
   assign w_over       = w_win | ((w_to | w_at_zero) & ~w_sd_hold);

   // Match FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_presc   <= '0;
         r_serve   <= '0;
         r_start_d <= 1'b1;
         stop      <= 1'b1;
         sec1      <= TENS;
         sec0      <= UNITS;
         score1    <= 4'd0;
         score2    <= 4'd0;
         winner    <= 2'b00;
         game_over <= 1'b0;
      end else begin
         r_start_d <= start;
         case (r_state)
            ST_IDLE: begin
               stop <= 1'b1;
               if (w_start_edge) begin
                  r_state <= ST_SERVE;
                  r_presc <= '0;
                  r_serve <= '0;
               end
            end
            ST_SERVE: begin
               stop <= 1'b1;
               if (w_tick) begin
                  r_presc <= '0;
                  if (r_serve == SW'(SERVE_SEC - 1)) begin
                     r_state <= ST_PLAY;
                     r_serve <= '0;
                     stop    <= 1'b0;
                  end else begin
                     r_serve <= r_serve + SW'(1);
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            ST_PLAY: begin
               r_presc <= w_tick ? '0 : r_presc + PW'(1);
               if (w_tick && !w_at_zero) begin
                  {sec1, sec0} <= w_sec_dec;
               end
               score1 <= w_s1_nxt;
               score2 <= w_s2_nxt;
               if (w_over) begin
                  r_state   <= ST_OVER;
                  r_presc   <= '0;
                  r_serve   <= '0;
                  stop      <= 1'b1;
                  game_over <= 1'b1;
                  winner    <= win_code(w_s1_nxt, w_s2_nxt);
               end else if (w_miss) begin
                  r_state <= ST_SERVE;
                  r_presc <= '0;
                  r_serve <= '0;
                  stop    <= 1'b1;
               end else begin
                  stop <= 1'b0;
               end
            end
            ST_OVER: begin
               stop <= 1'b1;
               if (w_start_edge) begin
                  r_state   <= ST_SERVE;
                  r_presc   <= '0;
                  r_serve   <= '0;
                  sec1      <= TENS;
                  sec0      <= UNITS;
                  score1    <= 4'd0;
                  score2    <= 4'd0;
                  winner    <= 2'b00;
                  game_over <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               stop    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against a seconds/score level match model.
module tb_pong_game_ctrl;

   localparam int SEC_CYCLES = 4;
   localparam int GAME_SEC   = 12;
   localparam int WIN_SCORE  = 3;
   localparam int SERVE_SEC  = 1;

   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, miss1, miss2;
   logic       stop, game_over;
   logic [3:0] sec1, sec0, score1, score2;
   logic [1:0] winner;

   int n_checks = 0;
   int n_errors = 0;

   int m_st, m_time, m_s1, m_s2, m_cnt, m_win, m_prev_start;

   pong_game_ctrl #(
      .SEC_CYCLES(SEC_CYCLES), .GAME_SEC(GAME_SEC),
      .WIN_SCORE(WIN_SCORE), .SERVE_SEC(SERVE_SEC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
      .stop(stop), .sec1(sec1), .sec0(sec0), .score1(score1), .score2(score2),
      .winner(winner), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
      end
   endtask

   function automatic int sd_tie(input int a, input int b);
`ifdef PONG_SUDDEN_DEATH_EN
      return (a == b) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic m_reset();
      m_st = M_IDLE; m_time = GAME_SEC; m_s1 = 0; m_s2 = 0;
      m_cnt = 0; m_win = 0; m_prev_start = 1;
   endtask

   task automatic m_goto(input int st);
      m_st  = st;
      m_cnt = 0;
      if (st == M_OVER) m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
   endtask

   // One clock edge of the match at the level of seconds and points
   task automatic m_step();
      int  edge_seen, ticked, hit_zero, pts1, pts2;
      edge_seen    = (start && !m_prev_start) ? 1 : 0;
      m_prev_start = start;
      case (m_st)
         M_IDLE: if (edge_seen != 0) m_goto(M_SERVE);
         M_SERVE: begin
            m_cnt++;
            if (m_cnt == SERVE_SEC * SEC_CYCLES) m_goto(M_PLAY);
         end
         M_PLAY: begin
            m_cnt++;
            ticked   = (m_cnt % SEC_CYCLES == 0) ? 1 : 0;
            hit_zero = 0;
            if (ticked != 0 && m_time > 0) begin
               m_time--;
               if (m_time == 0) hit_zero = 1;
            end
            pts1 = (miss2 && !miss1) ? 1 : 0;
            pts2 = (miss1 && !miss2) ? 1 : 0;
            m_s1 += pts1;
            m_s2 += pts2;
            if (miss1 || miss2) begin
               if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) m_goto(M_OVER);
               else if (m_time == 0 && sd_tie(m_s1, m_s2) == 0) m_goto(M_OVER);
               else m_goto(M_SERVE);
            end else if (hit_zero != 0 && sd_tie(m_s1, m_s2) == 0) begin
               m_goto(M_OVER);
            end
         end
         default: begin
            if (edge_seen != 0) begin
               m_s1 = 0; m_s2 = 0; m_time = GAME_SEC; m_win = 0;
               m_goto(M_SERVE);
            end
         end
      endcase
   endtask

   task automatic check_all(input string tag);
      logic [7:0] exp_sec;
      exp_sec = {4'(m_time / 10), 4'(m_time % 10)};
      chk({tag, ".stop"},   {7'd0, stop},      {7'd0, (m_st != M_PLAY)});
      chk({tag, ".time"},   {sec1, sec0},      exp_sec);
      chk({tag, ".score1"}, {4'd0, score1},    8'(m_s1));
      chk({tag, ".score2"}, {4'd0, score2},    8'(m_s2));
      chk({tag, ".winner"}, {6'd0, winner},    8'(m_win));
      chk({tag, ".over"},   {7'd0, game_over}, {7'd0, (m_st == M_OVER)});
   endtask

   task automatic cycle();
      @(posedge clk);
      m_step();
      #1;
      check_all("cyc");
   endtask

   int hold_n, hold_pat;

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         start = ($urandom_range(0, 39) == 0);
         if (hold_n == 0 && $urandom_range(0, 11) == 0) begin
            hold_pat = $urandom_range(1, 3);
            hold_n   = $urandom_range(1, 3);
         end
         miss1 = (hold_n > 0) && hold_pat[0];
         miss2 = (hold_n > 0) && hold_pat[1];
         if (hold_n > 0) hold_n--;
         cycle();
      end
      start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
   endtask

   initial begin
      hold_n = 0; hold_pat = 0;
      rst = 1'b0; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
      m_reset();
      #12;
      check_all("reset");
      rst = 1'b1;

      start = 1'b1; cycle(); start = 1'b0;
      repeat (10) cycle();
      miss1 = 1'b1; repeat (3) cycle(); miss1 = 1'b0;
      repeat (8) cycle();
      repeat (3) begin
         miss2 = 1'b1; cycle(); miss2 = 1'b0;
         repeat (8) cycle();
      end
      start = 1'b1; cycle(); start = 1'b0;
      repeat (60) cycle();

      rand_run(3000);

      // Mid-match asynchronous reset with the start button held down
      start = 1'b1; cycle(); start = 1'b0;
      repeat (6) cycle();
      miss2 = 1'b1; cycle(); miss2 = 1'b0;
      repeat (6) cycle();
      rst = 1'b0; start = 1'b1;
      #2;
      m_reset();
      check_all("async_rst");
      rst = 1'b1;
      repeat (10) cycle();
      start = 1'b0;
      rand_run(2000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
